// File: rtl/sap1_display_driver_pkg.sv
// ============================================================================
// Module   : sap1_display_driver_pkg
// Purpose  : Shared FSM encodings and 7-segment patterns for the SAP1 display.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sap1_display_driver_pkg;

    localparam logic [1:0] DISP_IDLE = 2'd0;
    localparam logic [1:0] DISP_CONV = 2'd1;
    localparam logic [1:0] DISP_DONE = 2'd2;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

endpackage

`default_nettype wire

// File: rtl/sap1_seg7_decoder.sv
// ============================================================================
// Module   : sap1_seg7_decoder
// Purpose  : Combinational BCD digit to 7-segment decoder with blank control.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sap1_seg7_decoder
    import sap1_display_driver_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sap1_display_driver.sv
// ============================================================================
// Module   : sap1_display_driver
// Purpose  : Serial double-dabble BCD conversion of the SAP1 output register
//            and multiplexed 7-segment scan. Define SAP1_DISP_SIGNED_EN for
//            two's complement input with a minus sign on the top digit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sap1_display_driver
    import sap1_display_driver_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  CK,
    input  logic                  MR,
    input  logic [DATA_W-1:0]     DATA_IN,
    output logic                  BUSY,
    output logic                  UPDATE,
    output logic [4*DIGITS-1:0]   BCD_OUT,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN
);

    localparam int c_acc_w   = 4 * DIGITS;
    localparam int c_iter_w  = $clog2(DATA_W + 1);
    localparam int c_presc_w = $clog2(SCAN_DIV);
    localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_iter_w-1:0]  c_iter_last  = c_iter_w'(DATA_W - 1);
    localparam logic [c_iter_w-1:0]  c_iter_one   = c_iter_w'(1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0]   c_idx_one    = c_idx_w'(1);
    localparam logic [DIGITS-1:0]    c_an_one     = DIGITS'(1);

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [DATA_W-1:0]        r_last;
    logic [DATA_W-1:0]        r_bin;
    logic [c_acc_w-1:0]       r_acc;
    logic [c_iter_w-1:0]      r_iter;
    logic [c_acc_w-1:0]       r_bcd;
    logic                     r_busy;
    logic                     r_update;
    logic [c_presc_w-1:0]     r_presc;
    logic [c_idx_w-1:0]       r_idx;
    logic [DIGITS-1:0]        r_an;
    logic [6:0]               r_seg;

    logic                     w_capture;
    logic [DATA_W-1:0]        w_mag;
    logic [c_acc_w-1:0]       w_adj;
    logic [c_acc_w+DATA_W-1:0] w_shift;
    logic [DIGITS-1:0]        w_blank;
    logic [3:0]               w_digit;
    logic [6:0]               w_dec_seg;
    logic [6:0]               w_seg_next;

`ifdef SAP1_DISP_SIGNED_EN
    logic                     r_sign;
    logic                     r_sign_disp;
    assign w_mag = DATA_IN[DATA_W-1] ? -DATA_IN : DATA_IN;
`else
    assign w_mag = DATA_IN;
`endif

    assign w_capture = (r_state == DISP_IDLE) && (DATA_IN != r_last);

    always_ff @(posedge CK) begin
        if (MR) begin
            r_state <= DISP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DISP_IDLE: if (DATA_IN != r_last)     w_state_next = DISP_CONV;
            DISP_CONV: if (r_iter == c_iter_last) w_state_next = DISP_DONE;
            DISP_DONE: w_state_next = DISP_IDLE;
            default:   w_state_next = DISP_IDLE;
        endcase
    end

    // Add-3 on every nibble >= 5, then shift the whole {bcd, bin} pair left
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? r_acc[4*i +: 4] + 4'd3
                                                           : r_acc[4*i +: 4];
    end
    assign w_shift = {w_adj, r_bin} << 1;

    always_ff @(posedge CK) begin
        if (MR) begin
            r_last   <= '0;
            r_bin    <= '0;
            r_acc    <= '0;
            r_iter   <= '0;
            r_bcd    <= '0;
            r_busy   <= 1'b0;
            r_update <= 1'b0;
`ifdef SAP1_DISP_SIGNED_EN
            r_sign      <= 1'b0;
            r_sign_disp <= 1'b0;
`endif
        end else begin
            r_busy   <= (w_state_next != DISP_IDLE);
            r_update <= (r_state == DISP_DONE);
            if (w_capture) begin
                r_last <= DATA_IN;
                r_bin  <= w_mag;
                r_acc  <= '0;
                r_iter <= '0;
`ifdef SAP1_DISP_SIGNED_EN
                r_sign <= DATA_IN[DATA_W-1];
`endif
            end else if (r_state == DISP_CONV) begin
                r_acc  <= w_shift[DATA_W +: c_acc_w];
                r_bin  <= w_shift[DATA_W-1:0];
                r_iter <= r_iter + c_iter_one;
            end else if (r_state == DISP_DONE) begin
                r_bcd  <= r_acc;
`ifdef SAP1_DISP_SIGNED_EN
                r_sign_disp <= r_sign;
`endif
            end
        end
    end

    // A digit above the units blanks when it and every digit above it are zero
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_units
            assign w_blank[i] = 1'b0;
        end else begin : g_upper
            assign w_blank[i] = ~|r_bcd[c_acc_w-1:4*i];
        end
    end

    assign w_digit = r_bcd[4*r_idx +: 4];

    sap1_seg7_decoder u_dec (
        .i_bcd   (w_digit),
        .i_blank (w_blank[r_idx]),
        .o_seg   (w_dec_seg)
    );

`ifdef SAP1_DISP_SIGNED_EN
    assign w_seg_next = (r_sign_disp && (r_idx == c_idx_last)) ? SEG_MINUS : w_dec_seg;
`else
    assign w_seg_next = w_dec_seg;
`endif

    always_ff @(posedge CK) begin
        if (MR) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= ~c_an_one;
            r_seg   <= SEG_0;
        end else begin
            if (r_presc == c_presc_last) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_one;
            end else begin
                r_presc <= r_presc + c_presc_one;
            end
            r_an  <= ~(c_an_one << r_idx);
            r_seg <= w_seg_next;
        end
    end

    assign BUSY    = r_busy;
    assign UPDATE  = r_update;
    assign BCD_OUT = r_bcd;
    assign SEG     = r_seg;
    assign AN      = r_an;

endmodule

`default_nettype wire

// File: tb/tb_sap1_display_driver.sv
// ============================================================================
// Module   : tb_sap1_display_driver
// Purpose  : Directed self-checking bench for sap1_display_driver (SCAN_DIV=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sap1_display_driver;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SB = 7'b0000000;
    localparam logic [6:0] SM = 7'b1000000;

`ifdef SAP1_DISP_SIGNED_EN
    localparam logic [15:0] E255 = 16'h0001;
    localparam logic [27:0] D255 = {SM, SB, SB, S1};
    localparam logic [15:0] E200 = 16'h0056;
    localparam logic [27:0] D200 = {SM, SB, S5, S6};
`else
    localparam logic [15:0] E255 = 16'h0255;
    localparam logic [27:0] D255 = {SB, S2, S5, S5};
    localparam logic [15:0] E200 = 16'h0200;
    localparam logic [27:0] D200 = {SB, S2, S0, S0};
`endif

    logic        CK = 1'b0;
    logic        MR = 1'b1;
    logic [7:0]  DATA_IN = 8'd0;
    logic        BUSY;
    logic        UPDATE;
    logic [15:0] BCD_OUT;
    logic [6:0]  SEG;
    logic [3:0]  AN;

    int errors = 0;
    int checks = 0;

    sap1_display_driver #(
        .DATA_W   (8),
        .DIGITS   (4),
        .SCAN_DIV (4)
    ) dut (
        .CK      (CK),
        .MR      (MR),
        .DATA_IN (DATA_IN),
        .BUSY    (BUSY),
        .UPDATE  (UPDATE),
        .BCD_OUT (BCD_OUT),
        .SEG     (SEG),
        .AN      (AN)
    );

    always #5 CK = ~CK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic capture_display(output logic [27:0] disp);
        disp = 'x;
        repeat (24) begin
            @(negedge CK);
            case (AN)
                4'b1110: disp[6:0]   = SEG;
                4'b1101: disp[13:7]  = SEG;
                4'b1011: disp[20:14] = SEG;
                4'b0111: disp[27:21] = SEG;
                default: disp = disp;
            endcase
        end
    endtask

    task automatic test_reset;
        DATA_IN = 8'd0;
        @(negedge CK);
        MR = 1'b1;
        repeat (2) @(posedge CK);
        @(negedge CK);
        checks++; if (BUSY !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (UPDATE !== 1'b0)      begin errors++; $display("FAIL reset_update: got %b want 0", UPDATE); end
        checks++; if (BCD_OUT !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h want 0000", BCD_OUT); end
        checks++; if (AN !== 4'b1110)       begin errors++; $display("FAIL reset_an: got %b want 1110", AN); end
        checks++; if (SEG !== S0)           begin errors++; $display("FAIL reset_seg: got %b want %b", SEG, S0); end
        MR = 1'b0;
    endtask

    task automatic test_scan;
        logic [3:0] one = 4'b0001;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         exp_idx;
        for (int k = 1; k <= 16; k++) begin
            @(posedge CK);
            @(negedge CK);
            exp_idx = ((k - 1) / 4) % 4;
            exp_an  = ~(one << exp_idx);
            exp_seg = (exp_idx == 0) ? S0 : SB;
            checks++; if (AN !== exp_an)   begin errors++; $display("FAIL scan_an[%0d]: got %b want %b", k, AN, exp_an); end
            checks++; if (SEG !== exp_seg) begin errors++; $display("FAIL scan_seg[%0d]: got %b want %b", k, SEG, exp_seg); end
            checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL scan_busy[%0d]: got %b want 0", k, BUSY); end
        end
        checks++; if (BCD_OUT !== 16'h0000) begin errors++; $display("FAIL scan_bcd: got %h want 0000", BCD_OUT); end
    endtask

    task automatic test_convert(input logic [7:0] v, input logic [15:0] exp_bcd,
                                input logic [27:0] exp_disp, input string name);
        int          busy_n = 0;
        int          upd_n  = 0;
        logic [15:0] upd_bcd = 'x;
        logic [27:0] disp;
        @(negedge CK);
        DATA_IN = v;
        repeat (20) begin
            @(negedge CK);
            if (BUSY === 1'b1) busy_n++;
            if (UPDATE === 1'b1) begin upd_n++; upd_bcd = BCD_OUT; end
        end
        checks++; if (busy_n != 9)        begin errors++; $display("FAIL %s_busy_cycles: got %0d want 9", name, busy_n); end
        checks++; if (upd_n != 1)         begin errors++; $display("FAIL %s_updates: got %0d want 1", name, upd_n); end
        checks++; if (upd_bcd !== exp_bcd) begin errors++; $display("FAIL %s_bcd_at_update: got %h want %h", name, upd_bcd, exp_bcd); end
        checks++; if (BCD_OUT !== exp_bcd) begin errors++; $display("FAIL %s_bcd: got %h want %h", name, BCD_OUT, exp_bcd); end
        capture_display(disp);
        checks++; if (disp !== exp_disp)  begin errors++; $display("FAIL %s_display: got %h want %h", name, disp, exp_disp); end
    endtask

    task automatic test_back_to_back;
        int          busy_n = 0;
        int          upd_n  = 0;
        logic [15:0] first_bcd = 'x;
        logic [15:0] second_bcd = 'x;
        logic [27:0] disp;
        @(negedge CK);
        DATA_IN = 8'd7;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CK);
            if (BUSY === 1'b1) busy_n++;
            if (UPDATE === 1'b1) begin
                upd_n++;
                if (upd_n == 1) first_bcd = BCD_OUT;
                else            second_bcd = BCD_OUT;
            end
            if (cyc == 2) DATA_IN = 8'd100;
        end
        checks++; if (upd_n != 2)             begin errors++; $display("FAIL b2b_updates: got %0d want 2", upd_n); end
        checks++; if (busy_n != 18)           begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 18", busy_n); end
        checks++; if (first_bcd !== 16'h0007) begin errors++; $display("FAIL b2b_first_bcd: got %h want 0007", first_bcd); end
        checks++; if (second_bcd !== 16'h0100) begin errors++; $display("FAIL b2b_second_bcd: got %h want 0100", second_bcd); end
        capture_display(disp);
        checks++; if (disp !== {SB, S1, S0, S0}) begin errors++; $display("FAIL b2b_display: got %h want %h", disp, {SB, S1, S0, S0}); end
    endtask

    task automatic test_reset_mid;
        int          busy_n = 0;
        int          upd_n  = 0;
        logic [27:0] disp;
        @(negedge CK);
        DATA_IN = 8'd200;
        repeat (5) @(negedge CK);
        MR = 1'b1;
        @(posedge CK);
        @(negedge CK);
        checks++; if (BUSY !== 1'b0)        begin errors++; $display("FAIL mid_reset_busy: got %b want 0", BUSY); end
        checks++; if (UPDATE !== 1'b0)      begin errors++; $display("FAIL mid_reset_update: got %b want 0", UPDATE); end
        checks++; if (BCD_OUT !== 16'h0000) begin errors++; $display("FAIL mid_reset_bcd: got %h want 0000", BCD_OUT); end
        checks++; if (AN !== 4'b1110)       begin errors++; $display("FAIL mid_reset_an: got %b want 1110", AN); end
        checks++; if (SEG !== S0)           begin errors++; $display("FAIL mid_reset_seg: got %b want %b", SEG, S0); end
        MR = 1'b0;
        repeat (20) begin
            @(negedge CK);
            if (BUSY === 1'b1) busy_n++;
            if (UPDATE === 1'b1) upd_n++;
        end
        checks++; if (busy_n != 9)       begin errors++; $display("FAIL mid_recap_busy_cycles: got %0d want 9", busy_n); end
        checks++; if (upd_n != 1)        begin errors++; $display("FAIL mid_recap_updates: got %0d want 1", upd_n); end
        checks++; if (BCD_OUT !== E200)  begin errors++; $display("FAIL mid_recap_bcd: got %h want %h", BCD_OUT, E200); end
        capture_display(disp);
        checks++; if (disp !== D200)     begin errors++; $display("FAIL mid_recap_display: got %h want %h", disp, D200); end
    endtask

    task automatic test_no_change;
        int busy_n = 0;
        int upd_n  = 0;
        @(negedge CK);
        DATA_IN = 8'd99;
        repeat (15) begin
            @(negedge CK);
            if (BUSY === 1'b1) busy_n++;
            if (UPDATE === 1'b1) upd_n++;
        end
        checks++; if (busy_n != 0)          begin errors++; $display("FAIL same_value_busy: got %0d want 0", busy_n); end
        checks++; if (upd_n != 0)           begin errors++; $display("FAIL same_value_updates: got %0d want 0", upd_n); end
        checks++; if (BCD_OUT !== 16'h0099) begin errors++; $display("FAIL same_value_bcd: got %h want 0099", BCD_OUT); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert(8'd255, E255, D255, "v255");
        test_back_to_back();
        test_reset_mid();
        test_convert(8'd10, 16'h0010, {SB, SB, S1, S0}, "v10");
        test_convert(8'd99, 16'h0099, {SB, SB, S9, S9}, "v99");
        test_no_change();
`ifdef SAP1_DISP_SIGNED_EN
        test_convert(8'h80, 16'h0128, {SM, S1, S2, S8}, "neg128");
        test_convert(8'hFB, 16'h0005, {SM, SB, SB, S5}, "neg5");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
